// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one shared bus slave port to NUM_MASTERS requesters.
// Optional slave watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MASTERS-1:0]           m_req,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic [NUM_MASTERS-1:0]           m_ack,
    output logic [NUM_MASTERS-1:0]           m_err,
    output logic                             s_req,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    input  logic                             s_ack
);

    localparam int GW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;

    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic [GW:0]     scan_base;
    logic [GW:0]     scan_cand;
    logic [GW-1:0]   scan_idx;
    logic            pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt;
`endif

    // Rotating priority scan starting after the last served master; the wrap
    // is explicit so non-power-of-two master counts never index past the end.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_cand  = '0;
        scan_idx   = '0;
        if ({1'b0, last_grant} == (GW+1)'(NUM_MASTERS - 1))
            scan_base = '0;
        else
            scan_base = {1'b0, last_grant} + (GW+1)'(1);
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            scan_cand = scan_base + (GW+1)'(i);
            if (scan_cand >= (GW+1)'(NUM_MASTERS))
                scan_cand = scan_cand - (GW+1)'(NUM_MASTERS);
            scan_idx = scan_cand[GW-1:0];
            if (!pick_valid && m_req[scan_idx]) begin
                pick       = scan_idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        pick_we    = m_we[pick];
        pick_addr  = m_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = m_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            m_rdata    <= '0;
            m_ack      <= '0;
            s_req      <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            m_err      <= '0;
            to_cnt     <= '0;
`endif
        end else begin
            m_ack <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            m_err <= '0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        s_we       <= pick_we;
                        s_addr     <= pick_addr;
                        s_wdata    <= pick_wdata;
                        s_req      <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A slave ack in the timeout cycle takes precedence over the abort.
                    if (s_ack) begin
                        m_rdata      <= s_rdata;
                        m_ack[grant] <= 1'b1;
                        s_req        <= 1'b0;
                        state        <= RELEASE;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    else if (to_cnt + 16'd1 == TO_LIMIT) begin
                        m_rdata      <= '0;
                        m_ack[grant] <= 1'b1;
                        m_err[grant] <= 1'b1;
                        s_req        <= 1'b0;
                        state        <= RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef BUS_ARBITER_TIMEOUT_EN
    assign m_err = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle vector table plus hand-written
// round-robin, reset-abort and watchdog sequences.
module tb_bus_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [DW-1:0]    m_rdata;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic             s_req;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [DW-1:0]    s_rdata;
    logic             s_ack;

    logic [31:0] a0, a1, d0, d1;
    assign m_addr  = {a1, a0};
    assign m_wdata = {d1, d0};

    bus_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ack(m_ack),
        .m_err(m_err),
        .s_req(s_req),
        .s_we(s_we),
        .s_addr(s_addr),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic        sack;
        logic [31:0] srd;
        logic        e_sreq;
        logic        e_swe;
        logic [31:0] e_saddr;
        logic [31:0] e_swdata;
        logic [1:0]  e_ack;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                                input logic [31:0] va0, input logic [31:0] va1,
                                input logic [31:0] vd0, input logic [31:0] vd1,
                                input logic sack, input logic [31:0] srd,
                                input logic e_sreq, input logic e_swe,
                                input logic [31:0] e_saddr, input logic [31:0] e_swdata,
                                input logic [1:0] e_ack, input logic [31:0] e_rdata);
        vec_t v;
        v.req = req; v.we = we; v.a0 = va0; v.a1 = va1; v.d0 = vd0; v.d1 = vd1;
        v.sack = sack; v.srd = srd;
        v.e_sreq = e_sreq; v.e_swe = e_swe; v.e_saddr = e_saddr; v.e_swdata = e_swdata;
        v.e_ack = e_ack; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required completion");
        summary();
        $fatal(1, "simulation time limit");
    end

    int rr_exp[6] = '{0, 1, 0, 1, 0, 1};
    int got;
    int last_cyc;

    initial begin
        reset = 1'b1;
        m_req = '0; m_we = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        s_rdata = '0; s_ack = 1'b0;

        // Master 1 write, immediate ack; master 0 read with 5 wait states;
        // s_ack in RELEASE/IDLE ignored; payload/request changes during BUSY ignored.
        vecs.push_back(mk(2'b10, 2'b10, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0,
                          1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0));
        vecs.push_back(mk(2'b10, 2'b10, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 32'hA5A50001,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'hA5A50001));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(2'b01, 2'b00, 32'h40, 32'h0, 32'h11111111, 32'h0, 1'b0, 32'h0,
                              1'b1, 1'b0, 32'h40, 32'h11111111, 2'b00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h40, 32'h0, 32'h11111111, 32'h0, 1'b1, 32'h12345678,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 32'h12345678));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h00000BAD,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h00000BAD,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h20, 32'h0, 32'h2222, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 32'h20, 32'h2222, 2'b00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h99, 32'h30, 32'h9999, 32'h3333, 1'b0, 32'h0,
                          1'b1, 1'b1, 32'h20, 32'h2222, 2'b00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h99, 32'h30, 32'h9999, 32'h3333, 1'b1, 32'h55,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 32'h55));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h30, 32'h0, 32'h3333, 1'b0, 32'h0,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h30, 32'h0, 32'h3333, 1'b0, 32'h0,
                          1'b1, 1'b0, 32'h30, 32'h3333, 2'b00, 32'h0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h30, 32'h0, 32'h3333, 1'b1, 32'h77,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h77));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0));

        // Reset values
        #12;
        chk("rst_s_req", s_req, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_rdata", m_rdata, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            m_req = vecs[i].req; m_we = vecs[i].we;
            a0 = vecs[i].a0; a1 = vecs[i].a1; d0 = vecs[i].d0; d1 = vecs[i].d1;
            s_ack = vecs[i].sack; s_rdata = vecs[i].srd;
            tick();
            chk($sformatf("v%0d_s_req", i), s_req, vecs[i].e_sreq);
            if (vecs[i].e_sreq) begin
                chk($sformatf("v%0d_s_we", i), s_we, vecs[i].e_swe);
                chk($sformatf("v%0d_s_addr", i), s_addr, vecs[i].e_saddr);
                chk($sformatf("v%0d_s_wdata", i), s_wdata, vecs[i].e_swdata);
            end
            chk($sformatf("v%0d_m_ack", i), m_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_m_err", i), m_err, 0);
            if (vecs[i].e_ack != 2'b00)
                chk($sformatf("v%0d_m_rdata", i), m_rdata, vecs[i].e_rdata);
        end

        // Both masters requesting continuously: alternating grants, 3 cycles each.
        m_req = 2'b11; m_we = 2'b00; a0 = 32'h100; a1 = 32'h200; s_ack = 1'b0;
        got = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            s_ack = s_req;
            tick();
            if (s_req)
                chk("rr_s_addr", s_addr, (rr_exp[got] == 1) ? 32'h200 : 32'h100);
            if (m_ack != 2'b00) begin
                chk("rr_grant", m_ack, (rr_exp[got] == 1) ? 32'h2 : 32'h1);
                if (got > 0)
                    chk("rr_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                got++;
            end
        end
        chk("rr_count", got, 6);
        m_req = 2'b00; s_ack = 1'b0;
        tick();
        tick();

        // Reset while master 0 is in BUSY: s_req drops at once, master 0 wins again.
        m_req = 2'b01;
        tick();
        chk("ab_s_req_busy", s_req, 1);
        chk("ab_s_addr_busy", s_addr, 32'h100);
        #3;
        reset = 1'b1;
        #1;
        chk("ab_s_req_async", s_req, 0);
        chk("ab_m_ack_async", m_ack, 0);
        chk("ab_s_addr_async", s_addr, 0);
        tick();
        chk("ab_m_ack_hold", m_ack, 0);
        reset = 1'b0;
        m_req = 2'b11;
        tick();
        chk("ab_s_req_after", s_req, 1);
        chk("ab_s_addr_after", s_addr, 32'h100);
        chk("ab_m_ack_after", m_ack, 0);
        s_ack = 1'b1; s_rdata = 32'hCAFEF00D;
        tick();
        chk("ab_m_ack_done", m_ack, 32'h1);
        chk("ab_m_rdata_done", m_rdata, 32'hCAFEF00D);
        m_req = 2'b00; s_ack = 1'b0;
        tick();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Slave never acks: abort after 4 BUSY cycles with error and zero data.
        m_req = 2'b10; a1 = 32'h300; s_rdata = 32'hFFFFFFFF;
        tick();
        chk("to_s_req_enter", s_req, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("to_s_req_%0d", k), s_req, 1);
            chk($sformatf("to_m_ack_%0d", k), m_ack, 0);
        end
        tick();
        chk("to_m_ack", m_ack, 32'h2);
        chk("to_m_err", m_err, 32'h2);
        chk("to_m_rdata", m_rdata, 0);
        chk("to_s_req_rel", s_req, 0);
        m_req = 2'b00;
        tick();
        tick();
        // Ack in the timeout cycle wins: normal completion.
        m_req = 2'b01;
        tick();
        tick();
        tick();
        tick();
        chk("tie_m_ack_pre", m_ack, 0);
        s_ack = 1'b1; s_rdata = 32'h600D;
        tick();
        chk("tie_m_ack", m_ack, 32'h1);
        chk("tie_m_err", m_err, 0);
        chk("tie_m_rdata", m_rdata, 32'h600D);
        m_req = 2'b00; s_ack = 1'b0;
        tick();
`else
        // Without the watchdog BUSY waits indefinitely.
        m_req = 2'b10; a1 = 32'h300;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("nto_s_req_%0d", k), s_req, 1);
            chk($sformatf("nto_m_ack_%0d", k), m_ack, 0);
        end
        m_req = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("nto_s_req_cleared", s_req, 0);
`endif

        summary();
        $finish;
    end

endmodule
